// File: rtl/reg_bank_arbiter.sv
// Shares a bank of FunSel/I/E registers between two requesters, expanding inc/dec into bursts.
// Define REG_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module reg_bank_arbiter #(
  parameter int NREGS = 4,
  parameter int WIDTH = 16,
  parameter int SELW  = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0Valid,
  input  logic [SELW-1:0]  Req0Sel,
  input  logic [2:0]       Req0FunSel,
  input  logic [WIDTH-1:0] Req0Data,
  input  logic [3:0]       Req0Count,
  output logic             Req0Ack,
  input  logic             Req1Valid,
  input  logic [SELW-1:0]  Req1Sel,
  input  logic [2:0]       Req1FunSel,
  input  logic [WIDTH-1:0] Req1Data,
  input  logic [3:0]       Req1Count,
  output logic             Req1Ack,
  output logic [2:0]       FunSel,
  output logic [WIDTH-1:0] I,
  output logic [NREGS-1:0] E,
  output logic             Busy,
  output logic             Owner,
  output logic             Err
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic             oor_r, oor_s;
  logic [NREGS-1:0] e_s;
  logic [2:0]       fun_s;
  logic [WIDTH-1:0] i_s;
  logic             busy_s, owner_s, ack0_s, ack1_s, err_s;
  logic             win_s;
  logic [SELW-1:0]  wsel_s;
  logic [2:0]       wfun_s;
  logic [WIDTH-1:0] wdata_s;
  logic [3:0]       wload_s;
`ifdef REG_ARB_RR_EN
  logic             rr_ptr_r, rr_ptr_s;
`endif

  function automatic logic in_range_f(input logic [SELW-1:0] s);
    return int'(s) < NREGS;
  endfunction

  function automatic logic [NREGS-1:0] onehot_f(input logic [SELW-1:0] s);
    logic [NREGS-1:0] v;
    v = '0;
    for (int k = 0; k < NREGS; k++) v[k] = (int'(s) == k);
    return v;
  endfunction

  // Winner selection and mux of the winning request fields
  always_comb begin
    win_s = 1'b0;
`ifdef REG_ARB_RR_EN
    if (Req0Valid && Req1Valid) win_s = rr_ptr_r;
    else                        win_s = Req1Valid;
`else
    if (Req0Valid) win_s = 1'b0;
    else           win_s = Req1Valid;
`endif
    wsel_s  = win_s ? Req1Sel    : Req0Sel;
    wfun_s  = win_s ? Req1FunSel : Req0FunSel;
    wdata_s = win_s ? Req1Data   : Req0Data;
    // Only inc/dec codes repeat; everything else is a single beat
    if (wfun_s == 3'b000 || wfun_s == 3'b001) wload_s = win_s ? Req1Count : Req0Count;
    else                                      wload_s = 4'd0;
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    oor_s   = oor_r;
    e_s     = E;
    fun_s   = FunSel;
    i_s     = I;
    busy_s  = Busy;
    owner_s = Owner;
    ack0_s  = 1'b0;
    ack1_s  = 1'b0;
    err_s   = 1'b0;
`ifdef REG_ARB_RR_EN
    rr_ptr_s = rr_ptr_r;
`endif
    case (state_r)
      IDLE: begin
        if (Req0Valid || Req1Valid) begin
          state_s = ISSUE;
          cnt_s   = wload_s;
          oor_s   = ~in_range_f(wsel_s);
          e_s     = onehot_f(wsel_s);
          fun_s   = wfun_s;
          i_s     = wdata_s;
          busy_s  = 1'b1;
          owner_s = win_s;
          ack0_s  = (wload_s == 4'd0) && !win_s;
          ack1_s  = (wload_s == 4'd0) && win_s;
          err_s   = (wload_s == 4'd0) && !in_range_f(wsel_s);
`ifdef REG_ARB_RR_EN
          rr_ptr_s = ~win_s;
`endif
        end else begin
          e_s    = '0;
          busy_s = 1'b0;
        end
      end
      ISSUE: begin
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
          e_s     = '0;
          busy_s  = 1'b0;
        end else begin
          cnt_s  = cnt_r - 4'd1;
          ack0_s = (cnt_r == 4'd1) && !Owner;
          ack1_s = (cnt_r == 4'd1) && Owner;
          err_s  = (cnt_r == 4'd1) && oor_r;
        end
      end
      default: begin
        state_s = IDLE;
        e_s     = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      oor_r   <= 1'b0;
      E       <= '0;
      FunSel  <= 3'b000;
      I       <= '0;
      Busy    <= 1'b0;
      Owner   <= 1'b0;
      Req0Ack <= 1'b0;
      Req1Ack <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      oor_r   <= oor_s;
      E       <= e_s;
      FunSel  <= fun_s;
      I       <= i_s;
      Busy    <= busy_s;
      Owner   <= owner_s;
      Req0Ack <= ack0_s;
      Req1Ack <= ack1_s;
      Err     <= err_s;
    end
  end

`ifdef REG_ARB_RR_EN
  // Round-robin pointer: points at the requester that lost the last grant
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rr_ptr_r <= 1'b0;
    else        rr_ptr_r <= rr_ptr_s;
  end
`endif

endmodule
